// File: rtl/bitcount_sched_pkg.sv
// bitcount_sched_pkg: shared widths and FSM encoding for the even-bit count scheduler
package bitcount_sched_pkg;
  localparam int NCLI = 3;
  localparam int XW = 8;
  localparam int CW = 3;
  typedef enum logic [2:0] {ARB, WSOC1, WSOC0, WDAV0, WDAV1, ACK, REL} state_t;
endpackage

// File: rtl/bitcount_sched_rr_pick.sv
// rr_pick: combinational round-robin pick over three requests starting at ptr
module rr_pick
  import bitcount_sched_pkg::*;
(
  input  logic [NCLI-1:0] req,
  input  logic [1:0]      ptr,
  output logic            valid,
  output logic [1:0]      idx
);
  logic [1:0] i1, i2;
  always_comb begin
    i1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    i2 = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    valid = |req;
    idx = req[ptr] ? ptr : req[i1] ? i1 : i2;
  end
endmodule

// File: rtl/bitcount_sched.sv
// bitcount_sched: time-shares one even-bit counting unit among three handshaking clients
module bitcount_sched
  import bitcount_sched_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          req1,
  input  logic          req2,
  input  logic          req3,
  input  logic [XW-1:0] x1,
  input  logic [XW-1:0] x2,
  input  logic [XW-1:0] x3,
  output logic          ack1,
  output logic          ack2,
  output logic          ack3,
  output logic [CW-1:0] c1,
  output logic [CW-1:0] c2,
  output logic [CW-1:0] c3,
  input  logic          soc,
  output logic          eoc,
  output logic [XW-1:0] x,
  input  logic          dav_,
  output logic          rfd,
  input  logic [CW-1:0] c
);
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, g_q, g_d, pick_i;
  logic [XW-1:0] x_q, x_d;
  logic [CW-1:0] r_q, r_d;
  logic eoc_q, eoc_d, rfd_q, rfd_d, pick_v;
  logic [NCLI-1:0] ack_q, ack_d, req;
  logic [CW-1:0] c_q [NCLI];
  logic [CW-1:0] c_d [NCLI];
  logic [XW-1:0] xs [NCLI];
  assign req = {req3, req2, req1};
  assign xs = '{x1, x2, x3};
  rr_pick u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_v),
    .idx  (pick_i)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
    x_d = x_q;
    r_d = r_q;
    eoc_d = eoc_q;
    rfd_d = rfd_q;
    ack_d = ack_q;
    c_d = c_q;
    case (state_q)
      ARB: if (pick_v) begin
        x_d = xs[pick_i];
        g_d = pick_i;
        state_d = WSOC1;
      end
      WSOC1: if (soc) begin
        eoc_d = 1'b0;
        state_d = WSOC0;
      end
      WSOC0: if (!soc) begin
        eoc_d = 1'b1;
        state_d = WDAV0;
      end
      WDAV0: if (!dav_) begin
        r_d = c;
        rfd_d = 1'b0;
        state_d = WDAV1;
      end
      WDAV1: if (dav_) begin
        rfd_d = 1'b1;
        c_d[g_q] = r_q;
        ack_d[g_q] = 1'b1;
        state_d = ACK;
      end
      ACK: if (!req[g_q]) begin
        ack_d[g_q] = 1'b0;
        ptr_d = g_q == 2'd2 ? 2'd0 : g_q + 2'd1;
        state_d = REL;
      end
      REL: state_d = ARB;
      default: state_d = ARB;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
      ptr_q <= 2'd0;
      g_q <= 2'd0;
      x_q <= '0;
      r_q <= '0;
      eoc_q <= 1'b1;
      rfd_q <= 1'b1;
      ack_q <= '0;
      c_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      x_q <= x_d;
      r_q <= r_d;
      eoc_q <= eoc_d;
      rfd_q <= rfd_d;
      ack_q <= ack_d;
      c_q <= c_d;
    end
  end
  assign {ack3, ack2, ack1} = ack_q;
  assign c1 = c_q[0];
  assign c2 = c_q[1];
  assign c3 = c_q[2];
  assign x = x_q;
  assign eoc = eoc_q;
  assign rfd = rfd_q;
endmodule

// File: tb/tb_bitcount_sched.sv
// tb_bitcount_sched: directed self-checking bench with a handshaking unit model
module tb_bitcount_sched;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req1 = 1'b0, req2 = 1'b0, req3 = 1'b0;
  logic [7:0] x1 = '0, x2 = '0, x3 = '0;
  logic soc = 1'b0, dav_ = 1'b1;
  logic [2:0] c = '0;
  logic ack1, ack2, ack3, eoc, rfd;
  logic [2:0] c1, c2, c3;
  logic [7:0] x;
  int n_cmp = 0, n_bad = 0;
  logic [2:0] exp_c [1:3] = '{3'd0, 3'd0, 3'd0};
  bitcount_sched dut (
    .clock(clock), .reset(reset),
    .req1(req1), .req2(req2), .req3(req3),
    .x1(x1), .x2(x2), .x3(x3),
    .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .c1(c1), .c2(c2), .c3(c3),
    .soc(soc), .eoc(eoc), .x(x), .dav_(dav_), .rfd(rfd), .c(c)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] even_cnt(input logic [7:0] v);
    return 3'(v[0]) + 3'(v[2]) + 3'(v[4]) + 3'(v[6]);
  endfunction
  function automatic logic sig(input int w);
    case (w)
      0: return eoc;
      1: return rfd;
      2: return ack1;
      3: return ack2;
      default: return ack3;
    endcase
  endfunction
  function automatic logic get_ack(input int k);
    return sig(k + 1);
  endfunction
  function automatic logic [2:0] get_c(input int k);
    return k == 1 ? c1 : k == 2 ? c2 : c3;
  endfunction
  task automatic set_req(input int k, input logic v);
    if (k == 1) req1 = v;
    else if (k == 2) req2 = v;
    else req3 = v;
  endtask
  task automatic wait_sig(input string tag, input int w, input logic v);
    int n = 0;
    while (sig(w) !== v && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(sig(w)), 32'(v));
  endtask
  task automatic serve(input int k, input logic [7:0] xv, input logic [2:0] expc, input int other, input bit early);
    @(negedge clock);
    soc = 1'b1;
    wait_sig($sformatf("eoc_fall_%0d", k), 0, 1'b0);
    chk($sformatf("x_op_%0d", k), 32'(x), 32'(xv));
    if (other != 0) set_req(other, 1'b1);
    if (early) set_req(k, 1'b0);
    soc = 1'b0;
    wait_sig($sformatf("eoc_rise_%0d", k), 0, 1'b1);
    chk($sformatf("x_hold_%0d", k), 32'(x), 32'(xv));
    c = even_cnt(x);
    dav_ = 1'b0;
    wait_sig($sformatf("rfd_fall_%0d", k), 1, 1'b0);
    dav_ = 1'b1;
    wait_sig($sformatf("rfd_rise_%0d", k), 1, 1'b1);
    exp_c[k] = expc;
    for (int j = 1; j <= 3; j++) begin
      chk($sformatf("ack%0d_at_%0d", j, k), 32'(get_ack(j)), 32'(j == k));
      chk($sformatf("c%0d_at_%0d", j, k), 32'(get_c(j)), 32'(exp_c[j]));
    end
    set_req(k, 1'b0);
    @(negedge clock);
    chk($sformatf("ack%0d_drop", k), 32'(get_ack(k)), 32'd0);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_eoc"}, 32'(eoc), 32'd1);
    chk({tag, "_rfd"}, 32'(rfd), 32'd1);
    chk({tag, "_ack"}, 32'({ack3, ack2, ack1}), 32'd0);
    chk({tag, "_c"}, 32'({c3, c2, c1}), 32'd0);
    chk({tag, "_x"}, 32'(x), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk_reset_state("rst");
    reset = 1'b0;
    x1 = 8'hFF; x2 = 8'h01; x3 = 8'h14;
    req1 = 1'b1; req2 = 1'b1; req3 = 1'b1;
    serve(1, 8'hFF, 3'd4, 0, 1'b0);
    serve(2, 8'h01, 3'd1, 0, 1'b0);
    serve(3, 8'h14, 3'd2, 0, 1'b0);
    x1 = 8'h40; x3 = 8'h11;
    req1 = 1'b1; req3 = 1'b1;
    serve(1, 8'h40, 3'd1, 0, 1'b0);
    serve(3, 8'h11, 3'd2, 0, 1'b0);
    x2 = 8'b01010101;
    req2 = 1'b1;
    serve(2, 8'h55, 3'd4, 0, 1'b0);
    x1 = 8'hAA;
    req1 = 1'b1;
    repeat (20) @(negedge clock);
    chk("slow_eoc", 32'(eoc), 32'd1);
    chk("slow_x", 32'(x), 32'hAA);
    chk("slow_ack1", 32'(ack1), 32'd0);
    serve(1, 8'hAA, 3'd0, 0, 1'b0);
    x3 = 8'h50; x1 = 8'h45;
    req3 = 1'b1;
    serve(3, 8'h50, 3'd2, 1, 1'b0);
    serve(1, 8'h45, 3'd3, 0, 1'b0);
    x2 = 8'h15;
    req2 = 1'b1;
    serve(2, 8'h15, 3'd3, 0, 1'b1);
    x2 = 8'h05;
    req2 = 1'b1;
    @(negedge clock);
    soc = 1'b1;
    wait_sig("rst_eoc_fall", 0, 1'b0);
    soc = 1'b0;
    wait_sig("rst_eoc_rise", 0, 1'b1);
    reset = 1'b1;
    req2 = 1'b0;
    @(negedge clock);
    chk_reset_state("midrst");
    exp_c = '{3'd0, 3'd0, 3'd0};
    reset = 1'b0;
    x1 = 8'h04; x2 = 8'h10; x3 = 8'hFE;
    req1 = 1'b1; req2 = 1'b1; req3 = 1'b1;
    serve(1, 8'h04, 3'd1, 0, 1'b0);
    serve(2, 8'h10, 3'd1, 0, 1'b0);
    serve(3, 8'hFE, 3'd3, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bitcount_sched.md
BITCOUNT_SCHED -- requirements
Module: bitcount_sched

Interface
REQ-001 The block SHALL have exactly one clock domain and a synchronous, active-high reset.
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 req1/req2/req3  in  1  client k request (4-phase handshake; x_k stable while high).
REQ-005 x1/x2/x3  in  8  client k operand.
REQ-006 ack1/ack2/ack3  out  1  client k acknowledge; c_k valid while high.
REQ-007 c1/c2/c3  out  3  client k result (count of 1s at even positions of x_k).
REQ-008 soc  in  1  shared unit requests new operand.
REQ-009 eoc  out  1  operand handshake toward unit; low = producing, high = operand valid.
REQ-010 x  out  8  operand to unit.
REQ-011 dav_  in  1  unit result valid, active-low.
REQ-012 rfd  out  1  ready-for-data toward unit; low = result taken.
REQ-013 c  in  3  unit result.

Function
REQ-014 The block SHALL time-share one even-bit counting unit among three clients, one transaction at a time.
REQ-015 FSM states SHALL be ARB, WSOC1, WSOC0, WDAV0, WDAV1, ACK, REL; each wait state SHALL advance on the edge where its condition is sampled true and hold otherwise.
REQ-016 ARB: if any req_k=1, grant per round-robin, latch X<=x_k and G<=k, go WSOC1; else stay.
REQ-017 Round-robin: search order starts at client PTR; after serving k, PTR<=k+1 (3 wraps to 1); simultaneous requests resolved in this order.
REQ-018 WSOC1: x=X; on soc=1, eoc<=0, go WSOC0.
REQ-019 WSOC0: on soc=0, eoc<=1, go WDAV0; x SHALL equal X from WSOC1 until leaving WDAV0.
REQ-020 WDAV0: on dav_=0, R<=c, rfd<=0, go WDAV1.
REQ-021 WDAV1: on dav_=1, rfd<=1, c_G<=R, ack_G<=1, go ACK.
REQ-022 ACK: on req_G=0, ack_G<=0, PTR update, go REL.
REQ-023 REL: unconditional return to ARB (one idle cycle between grants).
REQ-024 Requests from non-granted clients SHALL be ignored until ARB; their ack and c SHALL not change.
REQ-025 c_k SHALL hold its last result until client k is served again.
REQ-026 A client dropping req_k before ack_k SHALL not abort the transaction; result is still delivered and ACK completes immediately when req_G=0.
REQ-027 Result width is 3 bits (max 4); c passes through unmodified, no arithmetic in this block.

Reset
REQ-028 On reset: state ARB, PTR=1, eoc=1, rfd=1, ack1..3=0, c1..3=0, X=0, R=0, x=0.
REQ-029 Reset mid-transaction SHALL abandon it without delivering a result; the unit is reset by the same system reset.

Structure
REQ-030 Shared package SHALL hold the state encoding, NCLI=3, operand width 8 and result width 3.
REQ-031 Round-robin selection SHALL be a sub-module rr_pick (inputs req[3], PTR; outputs valid, index), purely combinational.

Verification
REQ-032 Single request: req2=1, x2=8'b01010101, unit model returns 4 -> c2=3'd4, ack2=1; req2=0 -> ack2=0 next edge.
REQ-033 Simultaneous: req1=req2=req3=1 after reset -> service order 1,2,3; then req1,req3 again -> order 3... wait: PTR=1 after 3 -> order 1,3.
REQ-034 Slow unit: soc held 0 for 20 cycles -> eoc=1, state WSOC1, x stable; no ack.
REQ-035 Isolation: req1 pending during client-3 transaction -> ack1, c1 unchanged until client-3 ACK done.
REQ-036 Reset in WDAV0 -> next edge eoc=1, rfd=1, all ack=0, c=0, PTR=1, state ARB.
